// File: rtl/ucc_pkg.sv
// ucc_pkg: shared types and constants for the UCC shadow stack.
// Holds FSM state encodings, the address width and the reset-handler PC.
package ucc_pkg;

  localparam int AW = 16;

  localparam logic [AW-1:0] RESET_HANDLER_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_IN_UCC = 2'b01,
    ST_IRQ    = 2'b10,
    ST_VIOL   = 2'b11
  } ucc_state_e;

endpackage

// File: rtl/ucc_ret_stack.sv
// ucc_ret_stack: LIFO of return addresses with push/pop/replace/clear.
// Ports: push, pop, replace, clear, din -> dout (top, 0 when empty), depth, full, empty.
module ucc_ret_stack
  import ucc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic [PW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;
  logic          do_repl;

  assign full    = (sp == PW'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = IW'(sp);
  assign top_idx = IW'(sp - PW'(1));
  assign dout    = empty ? '0 : mem[top_idx];
  assign depth   = sp;

  // Guards keep the pointer inside [0, DEPTH]
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign do_repl = replace && !empty && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + PW'(1);
    end else if (do_pop) begin
      sp <= sp - PW'(1);
    end
  end

  // Storage is not reset; only the pointer matters
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end else if (do_repl) begin
      mem[top_idx] <= din;
    end
  end

endmodule

// File: rtl/ucc_shadow_stack_ctrl.sv
// ucc_shadow_stack_ctrl: FSM guarding UCC entry/exit with a return-address stack.
// In: pc, enter_ucc/ret_addr_in, exit_ucc, irq_enter/irq_exit. Out: reset, depth, top_addr, state.
module ucc_shadow_stack_ctrl
  import ucc_pkg::*;
#(
  parameter int            DEPTH         = 8,
  parameter logic [AW-1:0] RESET_HANDLER = RESET_HANDLER_DEF
) (
  input  logic                         clk,
  input  logic                         system_reset_n,
  input  logic [AW-1:0]                pc,
  input  logic                         enter_ucc,
  input  logic [AW-1:0]                ret_addr_in,
  input  logic                         exit_ucc,
  input  logic                         irq_enter,
  input  logic                         irq_exit,
  output logic                         reset,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [AW-1:0]                top_addr,
  output logic [1:0]                   state
);

  localparam int PW = $clog2(DEPTH + 1);

  ucc_state_e state_q;
  ucc_state_e state_n;
  ucc_state_e saved_q;
  ucc_state_e saved_n;
  logic       reset_q;

  logic       push;
  logic       pop;
  logic       replace;
  logic       clear;
  logic       full;
  logic       empty;
  logic [PW-1:0] sdepth;
  logic [AW-1:0] stop;

  ucc_ret_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (system_reset_n),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .replace (replace),
    .din     (ret_addr_in),
    .dout    (stop),
    .depth   (sdepth),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      reset_q <= 1'b0;
    end else begin
      state_q <= state_n;
      saved_q <= saved_n;
      reset_q <= (state_n == ST_VIOL);
    end
  end

  always_comb begin
    state_n = state_q;
    saved_n = saved_q;
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (irq_enter) begin
          saved_n = ST_IDLE;
          state_n = ST_IRQ;
        end else if (enter_ucc) begin
          push    = 1'b1;
          state_n = ST_IN_UCC;
        end
      end
      ST_IN_UCC: begin
        if (irq_enter) begin
          saved_n = ST_IN_UCC;
          state_n = ST_IRQ;
        end else if (exit_ucc) begin
          // Exit is checked before any coincident enter
          if (empty || pc != stop) begin
            state_n = ST_VIOL;
          end else if (enter_ucc) begin
            replace = 1'b1;
          end else begin
            pop = 1'b1;
            if (sdepth == PW'(1)) begin
              state_n = ST_IDLE;
            end
          end
        end else if (enter_ucc) begin
          if (full) begin
            state_n = ST_VIOL;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_IRQ: begin
        if (irq_exit) begin
          state_n = saved_q;
        end
      end
      ST_VIOL: begin
        if (pc == RESET_HANDLER) begin
          clear   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign reset    = reset_q;
  assign depth    = sdepth;
  assign top_addr = stop;
  assign state    = state_q;

endmodule

// File: tb/tb_ucc_shadow_stack_ctrl.sv
// tb_ucc_shadow_stack_ctrl: scoreboard bench with a queue-based reference model.
// Directed sequences, then randomized traffic, checked every cycle by a monitor.
module tb_ucc_shadow_stack_ctrl;

  localparam int D  = 8;
  localparam int DW = $clog2(D + 1);
  localparam logic [15:0] RH = 16'h0000;

  localparam int M_IDLE = 0;
  localparam int M_IN   = 1;
  localparam int M_IRQ  = 2;
  localparam int M_VIOL = 3;

  typedef struct packed {
    logic [1:0]    st;
    logic [DW-1:0] dp;
    logic [15:0]   top;
    logic          rst;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   pc = '0;
  logic          enter_ucc = 1'b0;
  logic [15:0]   ret_addr_in = '0;
  logic          exit_ucc = 1'b0;
  logic          irq_enter = 1'b0;
  logic          irq_exit = 1'b0;
  logic          reset;
  logic [DW-1:0] depth;
  logic [15:0]   top_addr;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;

  obs_t expq[$];
  int   mstk[$];
  int   mmode = M_IDLE;
  int   msaved = M_IDLE;

  always #5 clk = ~clk;

  ucc_shadow_stack_ctrl #(
    .DEPTH         (D),
    .RESET_HANDLER (RH)
  ) dut (
    .clk            (clk),
    .system_reset_n (rst_n),
    .pc             (pc),
    .enter_ucc      (enter_ucc),
    .ret_addr_in    (ret_addr_in),
    .exit_ucc       (exit_ucc),
    .irq_enter      (irq_enter),
    .irq_exit       (irq_exit),
    .reset          (reset),
    .depth          (depth),
    .top_addr       (top_addr),
    .state          (state)
  );

  function automatic obs_t cur();
    obs_t o;
    o.st  = state;
    o.dp  = depth;
    o.top = top_addr;
    o.rst = reset;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.st  = 2'(mmode);
    o.dp  = DW'(mstk.size());
    o.top = (mstk.size() != 0) ? 16'(mstk[mstk.size()-1]) : 16'h0000;
    o.rst = (mmode == M_VIOL);
    return o;
  endfunction

  task automatic chk(string nm, obs_t got, obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got st=%0d dp=%0d top=%h rst=%b, want st=%0d dp=%0d top=%h rst=%b",
               nm, got.st, got.dp, got.top, got.rst,
               want.st, want.dp, want.top, want.rst);
    end
  endtask

  // Reference model: spec rules applied to a plain queue
  task automatic model_step(bit en, logic [15:0] ra, bit ex,
                            logic [15:0] p, bit ie, bit ix);
    case (mmode)
      M_IDLE: begin
        if (ie) begin
          msaved = M_IDLE;
          mmode  = M_IRQ;
        end else if (en) begin
          mstk.push_back(int'(ra));
          mmode = M_IN;
        end
      end
      M_IN: begin
        if (ie) begin
          msaved = M_IN;
          mmode  = M_IRQ;
        end else if (ex) begin
          if (mstk.size() == 0) begin
            mmode = M_VIOL;
          end else if (int'(p) != mstk[mstk.size()-1]) begin
            mmode = M_VIOL;
          end else if (en) begin
            mstk[mstk.size()-1] = int'(ra);
          end else begin
            void'(mstk.pop_back());
            if (mstk.size() == 0) mmode = M_IDLE;
          end
        end else if (en) begin
          if (mstk.size() == D) mmode = M_VIOL;
          else mstk.push_back(int'(ra));
        end
      end
      M_IRQ: begin
        if (ix) mmode = msaved;
      end
      default: begin
        if (p == RH) begin
          mstk.delete();
          mmode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic cyc(bit en, logic [15:0] ra, bit ex,
                     logic [15:0] p, bit ie, bit ix);
    @(negedge clk);
    enter_ucc   = en;
    ret_addr_in = ra;
    exit_ucc    = ex;
    pc          = p;
    irq_enter   = ie;
    irq_exit    = ix;
    model_step(en, ra, ex, p, ie, ix);
    expq.push_back(model_obs());
  endtask

  task automatic zero_inputs();
    enter_ucc   = 1'b0;
    ret_addr_in = '0;
    exit_ucc    = 1'b0;
    pc          = 16'h5555;
    irq_enter   = 1'b0;
    irq_exit    = 1'b0;
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] a;
    case ($urandom_range(0, 7))
      0: a = 16'hE010;
      1: a = 16'hE020;
      2: a = 16'hE030;
      3: a = 16'hE040;
      4: a = 16'h1234;
      5: a = 16'hBEEF;
      6: a = 16'hE050;
      default: a = 16'h0000;
    endcase
    return a;
  endfunction

  // Monitor: DUT outputs are live every cycle; compare just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        n_cyc++;
        chk($sformatf("cycle%0d", n_cyc), cur(), expq.pop_front());
      end
    end
  end

  initial begin
    obs_t idle_o;
    idle_o = '0;
    zero_inputs();
    #2;
    chk("reset_state", cur(), idle_o);
    @(negedge clk);
    rst_n = 1'b1;

    // simple enter/exit
    cyc(1, 16'hE010, 0, 16'h5555, 0, 0);
    cyc(0, 16'h0000, 1, 16'hE010, 0, 0);
    cyc(0, 16'h0000, 1, 16'hE010, 0, 0);

    // mismatched exit, then hold in VIOL until reset handler
    cyc(1, 16'hE010, 0, 16'h5555, 0, 0);
    cyc(1, 16'hE020, 0, 16'h5555, 0, 0);
    cyc(0, 16'h0000, 1, 16'hE010, 0, 0);
    cyc(1, 16'hE030, 0, 16'h4444, 0, 0);
    cyc(0, 16'h0000, 0, 16'h4444, 1, 0);
    cyc(0, 16'h0000, 0, RH, 0, 0);
    cyc(0, 16'h0000, 0, 16'h4444, 0, 0);

    // overflow
    for (int i = 0; i < D + 1; i++) begin
      cyc(1, 16'hA000 + 16'(i), 0, 16'h5555, 0, 0);
    end
    cyc(0, 16'h0000, 0, RH, 0, 0);

    // exit during IRQ is ignored
    cyc(1, 16'hE010, 0, 16'h5555, 0, 0);
    cyc(1, 16'hE020, 0, 16'h5555, 1, 0);
    cyc(0, 16'h0000, 1, 16'h1234, 0, 0);
    cyc(0, 16'h0000, 0, 16'h5555, 0, 1);

    // coincident valid exit and enter replaces the top
    cyc(0, 16'h0000, 1, 16'hE010, 0, 0);
    cyc(1, 16'hE010, 0, 16'h5555, 0, 0);
    cyc(1, 16'hE030, 1, 16'hE010, 0, 0);

    // build depth 3, then asynchronous reset mid-cycle
    cyc(1, 16'hE040, 0, 16'h5555, 0, 0);
    cyc(1, 16'hE050, 0, 16'h5555, 0, 0);
    @(posedge clk);
    #2;
    zero_inputs();
    rst_n = 1'b0;
    #1;
    chk("async_reset", cur(), idle_o);
    mstk.delete();
    mmode  = M_IDLE;
    msaved = M_IDLE;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit en, ex, ie, ix;
      logic [15:0] ra, p;
      en = ($urandom_range(0, 2) == 0);
      ex = ($urandom_range(0, 2) == 0);
      ie = ($urandom_range(0, 11) == 0);
      ix = (mmode == M_IRQ) ? ($urandom_range(0, 2) == 0)
                            : ($urandom_range(0, 19) == 0);
      ra = pick_addr();
      p  = pick_addr();
      if (mmode == M_IN && mstk.size() != 0 && $urandom_range(0, 3) != 0) begin
        p = 16'(mstk[mstk.size()-1]);
      end
      if (mmode == M_VIOL && $urandom_range(0, 3) == 0) begin
        p = RH;
      end
      cyc(en, ra, ex, p, ie, ix);
    end

    @(negedge clk);
    zero_inputs();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ucc_shadow_stack_ctrl.md
UCC_SHADOW_STACK_CTRL -- requirements
Module: ucc_shadow_stack_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of nested return-address entries.
REQ-002 Parameter RESET_HANDLER, default 16'h0000: PC value that marks completion of a system reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 system_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 pc  input  16  current program counter.
REQ-006 enter_ucc  input  1  one-cycle strobe: control transfer into a UCC region.
REQ-007 ret_addr_in  input  16  return address to push; valid with enter_ucc.
REQ-008 exit_ucc  input  1  one-cycle strobe: control transfer out of a UCC region; pc holds the destination.
REQ-009 irq_enter  input  1  one-cycle strobe: interrupt taken.
REQ-010 irq_exit  input  1  one-cycle strobe: interrupt returned.
REQ-011 reset  output  1  registered violation/reset request to the system.
REQ-012 depth  output  $clog2(DEPTH+1)  current number of stacked entries.
REQ-013 top_addr  output  16  entry at top of stack; 16'h0000 when empty.
REQ-014 state  output  2  current FSM state.

Function
REQ-015 The FSM SHALL have four states: IDLE=2'b00, IN_UCC=2'b01, IRQ=2'b10, VIOL=2'b11.
REQ-016 In IDLE, enter_ucc SHALL push ret_addr_in, increment depth, and transition to IN_UCC; exit_ucc in IDLE SHALL be ignored.
REQ-017 In IN_UCC, enter_ucc SHALL push ret_addr_in (nesting) and stay in IN_UCC.
REQ-018 In IN_UCC, exit_ucc with pc == top_addr SHALL pop; if depth becomes 0, the FSM SHALL go to IDLE, otherwise stay in IN_UCC.
REQ-019 In IN_UCC, exit_ucc with pc != top_addr SHALL transition to VIOL.
REQ-020 If enter_ucc and exit_ucc coincide in IN_UCC, the exit check SHALL be evaluated first. A valid exit SHALL replace the top entry with ret_addr_in, leaving depth unchanged. An invalid exit SHALL go to VIOL with no push.
REQ-021 Push at depth == DEPTH (overflow) SHALL transition to VIOL, leaving the stack unchanged.
REQ-022 exit_ucc in IN_UCC at depth == 0 (underflow) SHALL transition to VIOL.
REQ-023 irq_enter in IDLE or IN_UCC SHALL save the prior state and go to IRQ.
REQ-024 In IRQ, enter_ucc and exit_ucc SHALL be ignored, and the stack and depth SHALL be frozen.
REQ-025 irq_exit in IRQ SHALL restore the saved state.
REQ-026 irq_enter SHALL take priority over enter_ucc and exit_ucc in the same cycle.
REQ-027 In VIOL, reset SHALL be 1 while pc != RESET_HANDLER.
REQ-028 When pc == RESET_HANDLER in VIOL, the FSM SHALL clear depth to 0 and go to IDLE; reset SHALL deassert on the following edge.
REQ-029 reset SHALL be registered, asserting on the first edge after the violating cycle (latency 1).
REQ-030 depth and top_addr SHALL reflect updates one cycle after the triggering strobe.
REQ-031 Stack pointer arithmetic SHALL never wrap; out-of-range pushes and pops are blocked by REQ-021 and REQ-022.

Reset
REQ-032 Assertion of system_reset_n low SHALL immediately force state=IDLE, depth=0, top_addr=16'h0000, reset=0, and saved state=IDLE.
REQ-033 Reset assertion during IN_UCC, IRQ or VIOL SHALL discard all stacked entries; stack storage contents need not be cleared.
REQ-034 Deassertion SHALL be synchronised externally; the block adds no reset synchroniser.

Structure
REQ-035 Package ucc_pkg SHALL hold the state encodings, the RESET_HANDLER default and the address width constant (16).
REQ-036 LIFO storage SHALL be a sub-module ucc_ret_stack with ports push, pop, replace, din, dout, depth, full and empty; the FSM remains in ucc_shadow_stack_ctrl.

Verification
REQ-037 Sequence: enter_ucc with ret_addr_in=16'hE010 from IDLE, then exit_ucc with pc=16'hE010 -> depth goes 1 then 0, state goes IN_UCC then IDLE, reset stays 0.
REQ-038 Sequence: enter with 16'hE010, enter with 16'hE020, exit with pc=16'hE010 -> state=VIOL, reset=1 one cycle later; reset SHALL hold until pc=16'h0000, then state=IDLE, depth=0, reset=0.
REQ-039 With DEPTH=8: issue 8 nested pushes, then a 9th -> state=VIOL, depth remains 8.
REQ-040 Enter with 16'hE010, then irq_enter, then exit_ucc with pc=16'h1234 inside IRQ, then irq_exit -> no violation, state=IN_UCC, depth=1, top_addr=16'hE010.
REQ-041 Enter with 16'hE010, then simultaneous exit (pc=16'hE010) and enter (ret_addr_in=16'hE030) -> depth=1, top_addr=16'hE030, state=IN_UCC.
REQ-042 At depth=3 in IN_UCC, assert system_reset_n low mid-cycle -> outputs become IDLE/0/16'h0000/0 immediately, without waiting for a clock edge.
